data_scanner: RTL and testbench
===============================

// Module: data_scanner
// PURPOSE
//  Transmit-side counterpart of the 64-channel data demultiplexer. Snapshots 64 x 11-bit
//  channel words in one cycle, then emits them one at a time as (data, dataChange index) pairs.
//  Each word is held stable for DWELL clocks, so a receiver sampling once per DWELL window latches every channel.
//  Sits between the signal-generation logic and the serial/index link feeding the receiver.
// PARAMETERS
//  DWELL       11  clocks each word/index pair is held; legal range 2..16
//  CONTINUOUS  0   1 = re-snapshot and restart at index 0 after index 63 with no gap; 0 = one frame per start
// PORTS
//  clk         in   1     system clock; all logic on posedge
//  rst         in   1     synchronous, active-high reset
//  start       in   1     level/pulse; sampled only in IDLE; begins a frame
//  data_in     in   704   flat channel bus; channel k = data_in[11*k+10 : 11*k], k = 0..63
//  data        out  11    current channel word (registered)
//  dataChange  out  6     index of current word, 0..63 (registered)
//  valid       out  1     high while data/dataChange carry a frame word
//  busy        out  1     high in SEND state
//  frame_done  out  1     one-cycle pulse after the last hold cycle of index 63
//  checksum    out  11    sum of the 64 words of the last frame, mod 2048
// BEHAVIOUR
//  - Reset: state=IDLE; data=0, dataChange=0, valid=0, busy=0, frame_done=0, checksum=0; snapshot cleared.
//  - Two states: IDLE and SEND. All outputs registered; no combinational input->output paths.
//  - IDLE & start=1 at edge E: all 64 channels captured into the snapshot at E.
//    - From E+1: state=SEND, dataChange=0, data=snap[0], valid=1, busy=1, dwell=0.
//  - SEND, per clock: dwell increments; dataChange/data stay constant while dwell < DWELL-1.
//  - Index advance: at dwell==DWELL-1 and index<63, next cycle index+1, data=snap[index+1], dwell=0.
//  - Frame end: at dwell==DWELL-1 and index==63:
//    - CONTINUOUS=0: next cycle IDLE. valid=0, busy=0, data and dataChange return to 0, frame_done=1 for that one cycle.
//    - CONTINUOUS=1: data_in re-captured at that edge. Next cycle index=0 with the new snap[0], busy stays 1, frame_done=1 for one cycle.
//  - Frame length: exactly 64*DWELL cycles from first word to frame_done.
//  - data_in changes during SEND have no effect on the frame in progress; only the snapshot is sent.
//  - start while in SEND is ignored, with no queuing. start held high in IDLE re-triggers on the cycle after frame_done.
//  - rst mid-frame: next cycle all outputs at reset values; frame_done is not pulsed.
//  - Counters: dwell is 4 bits and index is 6 bits; index never wraps except through the frame-end rule.
// CONFIGURATION
//  - SCAN_CHECKSUM_EN defined:
//    - An 11-bit accumulator adds each word at its first hold cycle; wrap-around mod 2048 is intended.
//    - checksum updates in the same cycle frame_done pulses and holds until the next frame_done or rst.
//    - The accumulator clears at frame start.
//  - SCAN_CHECKSUM_EN undefined: no accumulator logic; checksum is tied to 0.
// TESTING
//  - Single frame, DWELL=11, channel k = 3k+5, start pulse at E:
//    - Cycles E+1..E+11: dataChange=0, data=5. Cycles E+694..E+704: dataChange=63, data=194.
//    - frame_done=1 at E+705 only; valid=0 from E+705.
//  - Snapshot isolation: after start, set all channels to 0x7FF mid-frame -> emitted words stay 3k+5; next frame sends 0x7FF.
//  - start held high, CONTINUOUS=0 -> new frame index 0 begins at E+706; start pulsed at E+300 during SEND -> ignored.
//  - CONTINUOUS=1 -> index 63 is followed directly by index 0 at E+705, with no valid gap and frame_done=1 that cycle.
//  - rst=1 at E+350 (mid index 31) -> at E+351 data=0, dataChange=0, valid=0, busy=0; frame_done never pulses.
//  - SCAN_CHECKSUM_EN, channel k = 3k+5 -> checksum=224 at frame_done. All channels 0x7FF -> checksum=0x7C0 (64*2047 mod 2048).
//  - Without SCAN_CHECKSUM_EN -> checksum stays 0.

Source files
------------

// File: rtl/data_scanner.sv
// Snapshots 64 x 11-bit channel words and emits them one per DWELL clocks as (data, dataChange) pairs.
// Optional SCAN_CHECKSUM_EN adds a mod-2048 checksum of each frame; otherwise checksum is tied to 0.
module data_scanner #(
   parameter int DWELL      = 11,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [703:0]  data_in,
   output logic [10:0]   data,
   output logic [5:0]    dataChange,
   output logic          valid,
   output logic          busy,
   output logic          frame_done,
   output logic [10:0]   checksum
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [3:0] LAST = 4'(DWELL - 1);

   state_t        state;
   logic [703:0]  snap;
   logic [3:0]    dwell;
   logic [5:0]    next_idx;
   logic [10:0]   next_word;
   logic          frame_start;
   logic          last_hold;
   logic          advance;
   logic          frame_end;

   // dataChange doubles as the frame index; it is 0 whenever the scanner is idle.
   always_comb begin
      next_idx    = dataChange + 6'd1;
      next_word   = snap[int'(next_idx) * 11 +: 11];
      frame_start = (state == IDLE) && start;
      last_hold   = (state == SEND) && (dwell == LAST);
      advance     = last_hold && (dataChange != 6'd63);
      frame_end   = last_hold && (dataChange == 6'd63);
   end

   // busy mirrors state exactly (high only in SEND) and serves as the state observation point.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         snap       <= '0;
         dwell      <= '0;
         data       <= '0;
         dataChange <= '0;
         valid      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_start) begin
            state      <= SEND;
            snap       <= data_in;
            data       <= data_in[10:0];
            dataChange <= '0;
            dwell      <= '0;
            valid      <= 1'b1;
            busy       <= 1'b1;
         end else if (advance) begin
            dataChange <= next_idx;
            data       <= next_word;
            dwell      <= '0;
         end else if (frame_end) begin
            frame_done <= 1'b1;
            dwell      <= '0;
            dataChange <= '0;
            if (CONTINUOUS) begin
               snap <= data_in;
               data <= data_in[10:0];
            end else begin
               state <= IDLE;
               data  <= '0;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         end else if (state == SEND) begin
            dwell <= dwell + 4'd1;
         end
      end
   end

`ifdef SCAN_CHECKSUM_EN
   logic [10:0] acc;

   // Each word is added on its first hold cycle; the frame's first word seeds the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         checksum <= '0;
      end else if (frame_start) begin
         acc <= data_in[10:0];
      end else if (advance) begin
         acc <= acc + next_word;
      end else if (frame_end) begin
         checksum <= acc;
         acc      <= CONTINUOUS ? data_in[10:0] : 11'd0;
      end
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_data_scanner.sv
// Directed bench for data_scanner: scoreboarded word stream, frame timing, snapshot isolation,
// start re-trigger, mid-frame reset and continuous-mode wrap on a second instance.
module tb_data_scanner;

   localparam int DWELL0 = 11;
   localparam int DWELL1 = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, start1;
   logic [703:0]  data_in, data_in1;
   logic [10:0]   data, data1;
   logic [5:0]    data_change, data_change1;
   logic          valid, valid1, busy, busy1, frame_done, frame_done1;
   logic [10:0]   checksum, checksum1;

   int n_checks = 0;
   int n_pass   = 0;
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;

   data_scanner #(.DWELL(DWELL0), .CONTINUOUS(1'b0)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in),
      .data(data), .dataChange(data_change), .valid(valid), .busy(busy),
      .frame_done(frame_done), .checksum(checksum)
   );

   data_scanner #(.DWELL(DWELL1), .CONTINUOUS(1'b1)) dut_c (
      .clk(clk), .rst(rst), .start(start1), .data_in(data_in1),
      .data(data1), .dataChange(data_change1), .valid(valid1), .busy(busy1),
      .frame_done(frame_done1), .checksum(checksum1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [703:0] pack(input int mul, input int add);
      logic [703:0] v;
      for (int k = 0; k < 64; k++) v[11*k +: 11] = 11'(mul * k + add);
      return v;
   endfunction

   task automatic push_frame(input int mul, input int add);
      for (int k = 0; k < 64; k++) exp_q.push_back({6'(k), 11'(mul * k + add)});
   endtask

   // Monitor: pops one expected word each time a new word appears and checks the previous hold length.
   logic       m_prev_valid = 1'b0;
   logic [5:0] m_prev_idx   = '0;
   int         m_hold       = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_prev_valid = 1'b0;
      end else begin
         if (valid && (!m_prev_valid || data_change != m_prev_idx)) begin
            if (m_prev_valid) check("hold_len", 32'(m_hold), 32'(DWELL0));
            if (exp_q.size() == 0) check("unexpected_word", {15'd0, data_change, data}, 32'h1ffff);
            else check("word", {15'd0, data_change, data}, {15'd0, exp_q.pop_front()});
            m_hold = 1;
         end else if (valid) begin
            m_hold++;
         end
         m_prev_valid = valid;
         m_prev_idx   = data_change;
      end
   end

   int          n_done;
   int          gaps;
   logic        fd_seen;
   logic [10:0] sum_a;
   logic [10:0] exp_ck_a, exp_ck_f, exp_ck_c;

   initial begin
      rst = 1'b1; start = 1'b0; start1 = 1'b0;
      data_in = '0; data_in1 = '0;
      sum_a = '0;
      for (int k = 0; k < 64; k++) sum_a = sum_a + 11'(7 * k + 1);
`ifdef SCAN_CHECKSUM_EN
      exp_ck_a = 11'd224; exp_ck_f = 11'h7C0; exp_ck_c = sum_a;
`else
      exp_ck_a = '0; exp_ck_f = '0; exp_ck_c = '0;
`endif
      repeat (3) tick();
      check("rst_data", 32'(data), 0);
      check("rst_index", 32'(data_change), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_checksum", 32'(checksum), 0);
      check("rst_valid_c", 32'(valid1), 0);
      rst = 1'b0;
      tick();

      // Frame 1: channel k = 3k+5; mid-frame data change and stray start must not disturb it.
      data_in = pack(3, 5);
      push_frame(3, 5);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("f1_first_valid", 32'(valid), 1);
      check("f1_first_busy", 32'(busy), 1);
      check("f1_first_index", 32'(data_change), 0);
      check("f1_first_data", 32'(data), 5);
      n_done = 0;
      for (int n = 1; n <= 800; n++) begin
         tick();
         if (n == 100) data_in = pack(0, 2047);
         if (n == 300) start = 1'b1;
         if (n == 301) start = 1'b0;
         if (n == 693) begin
            check("f1_last_index", 32'(data_change), 63);
            check("f1_last_data", 32'(data), 194);
         end
         if (frame_done) begin
            n_done = n;
            break;
         end
      end
      check("f1_done_latency", 32'(n_done), 704);
      check("f1_end_valid", 32'(valid), 0);
      check("f1_end_busy", 32'(busy), 0);
      check("f1_end_data", 32'(data), 0);
      check("f1_end_index", 32'(data_change), 0);
      check("f1_checksum", 32'(checksum), 32'(exp_ck_a));
      tick();
      check("f1_done_pulse_width", 32'(frame_done), 0);
      check("f1_idle_valid", 32'(valid), 0);

      // Frame 2: all channels 0x7FF with start held high; it must re-trigger right after frame_done.
      push_frame(0, 2047);
      start = 1'b1;
      tick();
      check("f2_first_valid", 32'(valid), 1);
      n_done = 0;
      for (int n = 1; n <= 800; n++) begin
         tick();
         if (frame_done) begin
            n_done = n;
            break;
         end
      end
      check("f2_done_latency", 32'(n_done), 704);
      check("f2_checksum", 32'(checksum), 32'(exp_ck_f));
      push_frame(0, 2047);
      tick();
      start = 1'b0;
      check("f3_retrigger_valid", 32'(valid), 1);
      check("f3_retrigger_index", 32'(data_change), 0);
      check("f3_retrigger_data", 32'(data), 32'h7ff);
      check("f3_retrigger_done_low", 32'(frame_done), 0);

      // Reset in the middle of index 31 of frame 3.
      for (int n = 1; n <= 349; n++) tick();
      check("f3_pre_rst_index", 32'(data_change), 31);
      rst = 1'b1;
      tick();
      check("mid_rst_data", 32'(data), 0);
      check("mid_rst_index", 32'(data_change), 0);
      check("mid_rst_valid", 32'(valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_words_left", 32'(exp_q.size()), 32);
      exp_q.delete();
      rst = 1'b0;
      fd_seen = 1'b0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (frame_done || valid) fd_seen = 1'b1;
      end
      check("post_rst_silent", 32'(fd_seen), 0);
      check("post_rst_checksum", 32'(checksum), 0);

      // Continuous instance: index 63 flows straight into index 0 of a re-captured frame.
      data_in1 = pack(7, 1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      data_in1 = pack(5, 9);
      check("c_first_index", 32'(data_change1), 0);
      check("c_first_data", 32'(data1), 1);
      gaps = 0;
      for (int n = 1; n <= 127; n++) begin
         tick();
         if (!valid1 || frame_done1) gaps++;
      end
      check("c_no_gap", 32'(gaps), 0);
      check("c_last_index", 32'(data_change1), 63);
      check("c_last_data", 32'(data1), 442);
      tick();
      check("c_wrap_done", 32'(frame_done1), 1);
      check("c_wrap_valid", 32'(valid1), 1);
      check("c_wrap_busy", 32'(busy1), 1);
      check("c_wrap_index", 32'(data_change1), 0);
      check("c_wrap_data", 32'(data1), 9);
      check("c_checksum", 32'(checksum1), 32'(exp_ck_c));
      tick();
      tick();
      check("c_second_index", 32'(data_change1), 1);
      check("c_second_data", 32'(data1), 14);
      check("c_second_done_low", 32'(frame_done1), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("c_rst_valid", 32'(valid1), 0);
      check("queue_drained", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
